csa_accumulator: RTL
====================

# csa_accumulator

Sequential multi-operand adder. Accepts a stream of signed 32-bit operands over a valid/ready handshake and compresses each operand into redundant sum/carry registers with one 3:2 carry-save stage per cycle. On the last operand of a group, it performs a single carry-propagate resolve and presents the total with an overflow flag. It sits directly upstream of consumers of resolved sums and generalises the three-operand carry-save adder to groups of up to MAX_OPS operands.

## Interface
- WIDTH, 32: operand and result width, signed two's complement.
- MAX_OPS, 16: maximum operands per group; must be at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  signed operand.
- in_last  in  1  marks the final operand of the group.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  low WIDTH bits of the group total, or the saturated value (see Configuration).
- out_of  out  1  signed overflow: the total does not fit in WIDTH bits.
- out_trunc  out  1  the group was closed by reaching MAX_OPS operands with in_last low.
- out_count  out  clog2(MAX_OPS)+1  number of operands in the group.

## Operation
- Internal width IW = WIDTH + G, where G = clog2(MAX_OPS). Each operand is sign-extended to IW.
- Registers:
  - s_reg, c_reg: IW bits each.
  - cnt: clog2(MAX_OPS)+1 bits.
  - trunc_reg.
  - result registers.
- Three-state FSM:
  - ACC:
    - in_ready = 1.
    - On an accept (in_valid & in_ready):
      - s_reg <= s_reg ^ c_sh ^ x.
      - c_reg <= majority(s_reg, c_sh, x).
      - c_sh = c_reg << 1, truncated to IW bits.
      - x = the extended operand.
      - cnt <= cnt + 1.
    - Go to RESOLVE if in_last = 1, or if cnt+1 == MAX_OPS. In the second case, trunc_reg <= ~in_last.
  - RESOLVE:
    - in_ready = 0.
    - total = s_reg + (c_reg << 1), computed modulo 2^IW.
    - out_of = NOT all of bits total[IW-1:WIDTH-1] equal.
    - Latch total, out_of, out_trunc and out_count. Go to OUT.
  - OUT:
    - out_valid = 1; outputs are held stable.
    - On out_valid & out_ready: clear s_reg, c_reg, cnt and trunc_reg to 0, then go to ACC.
- A group of exactly one operand, in_last on the first beat, is legal. out_sum = that operand, out_of = 0.
- in_data and in_last are ignored when in_ready = 0. in_valid may be held high across OUT without effect.
- Reset:
  - State = ACC.
  - All registers = 0.
  - out_valid = 0, out_sum = 0, out_of = 0, out_trunc = 0, out_count = 0.
  - in_ready = 1 after reset deasserts.
- Reset asserted mid-group or in OUT discards the group. No partial output is produced.

## Timing
- Throughput: one operand per cycle in ACC, with no bubbles between operands.
- Latency: the last operand is accepted at edge k, RESOLVE runs during cycle k→k+1, and out_valid is high from edge k+1.
- Group-to-group gap:
  - in_ready is low during RESOLVE and OUT.
  - The earliest next accept is the cycle after the output handshake, so there are at least 2 dead cycles.
- out_valid, out_sum, out_of, out_trunc and out_count are registered outputs. in_ready is a decode of the state register only, with no combinational path from in_valid or out_ready.
- Backpressure: out_ready low holds OUT indefinitely; all outputs stay stable.

## Configuration
- CSA_ACC_SAT_EN defined: when out_of = 1, out_sum saturates:
  - 2^(WIDTH-1)-1 when total is positive (bit IW-1 = 0).
  - -2^(WIDTH-1) when total is negative.
  - out_of still reports the overflow.
- CSA_ACC_SAT_EN undefined: out_sum = total[WIDTH-1:0] (wrap-around), with out_of as above.

## Test plan
- Reset mid-group: accept 5 and 7, assert rst_n = 0 → out_valid = 0 and in_ready = 1 after release; a new group {1 last} → out_sum = 1, out_count = 1.
- Group {3, -10, 25 last}, out_ready = 1 → out_valid on the edge after the last accept, out_sum = 18, out_of = 0, out_count = 3, out_trunc = 0.
- Group {0x7FFFFFFF, 1 last} → out_of = 1; out_sum = 0x80000000 without CSA_ACC_SAT_EN, 0x7FFFFFFF with it.
- Group {0x80000000, 0x80000000, 0x7FFFFFFF, 0x7FFFFFFF, 2 last}: intermediate sums overflow but the total fits → out_sum = 0, out_of = 0.
- 16 operands of 1 with in_last never set → group closes after the 16th accept, out_sum = 16, out_count = 16, out_trunc = 1; in_ready = 0 until the output is accepted.
- out_ready held low for 10 cycles after out_valid → outputs stable, in_ready = 0, in_valid pulses ignored; the next group {4 last} after the handshake → out_sum = 4.

Source files
------------

// File: rtl/csa_accumulator.sv
// Sequential multi-operand adder: one 3:2 carry-save compression per accepted
// operand, single carry-propagate resolve per group. Optional saturation: CSA_ACC_SAT_EN.

module csa_cell (
   input  logic s,
   input  logic c,
   input  logic x,
   output logic s_n,
   output logic c_n
);
   assign s_n = s ^ c ^ x;
   assign c_n = (s & c) | (s & x) | (c & x);
endmodule

module csa_accumulator #(
   parameter int WIDTH   = 32,
   parameter int MAX_OPS = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_sum,
   output logic                        out_of,
   output logic                        out_trunc,
   output logic [$clog2(MAX_OPS):0]    out_count
);
   localparam int G  = $clog2(MAX_OPS);
   localparam int IW = WIDTH + G;
   localparam int CW = G + 1;

   typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   s_reg, c_reg;
   logic [IW-1:0]   x_ext, c_sh, s_nxt, c_nxt, total;
   logic [CW-1:0]   cnt, cnt_inc;
   logic            trunc_reg;
   logic            accept, hit_max, ovf;
   logic [WIDTH-1:0] res;

   assign x_ext   = {{G{in_data[WIDTH-1]}}, in_data};
   assign c_sh    = {c_reg[IW-2:0], 1'b0};
   assign accept  = in_valid & in_ready;
   assign cnt_inc = cnt + CW'(1);
   assign hit_max = (cnt_inc == CW'(MAX_OPS));

   genvar i;
   generate
      for (i = 0; i < IW; i++) begin : g_csa
         csa_cell u_cell (
            .s   (s_reg[i]),
            .c   (c_sh[i]),
            .x   (x_ext[i]),
            .s_n (s_nxt[i]),
            .c_n (c_nxt[i])
         );
      end
   endgenerate

   // The guard bits plus the WIDTH sign bit must all agree for the total to fit.
   assign total = s_reg + c_sh;
   assign ovf   = ~((&total[IW-1:WIDTH-1]) | ~(|total[IW-1:WIDTH-1]));

`ifdef CSA_ACC_SAT_EN
   always_comb begin
      res = total[WIDTH-1:0];
      if (ovf) res = total[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign res = total[WIDTH-1:0];
`endif

   assign in_ready = (state == ACC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (accept && (in_last || hit_max)) state_nxt = RESOLVE;
         RESOLVE: state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg     <= '0;
         c_reg     <= '0;
         cnt       <= '0;
         trunc_reg <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_of    <= 1'b0;
         out_trunc <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            ACC: if (accept) begin
               s_reg <= s_nxt;
               c_reg <= c_nxt;
               cnt   <= cnt_inc;
               if (hit_max) trunc_reg <= ~in_last;
            end
            RESOLVE: begin
               out_valid <= 1'b1;
               out_sum   <= res;
               out_of    <= ovf;
               out_trunc <= trunc_reg;
               out_count <= cnt;
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               s_reg     <= '0;
               c_reg     <= '0;
               cnt       <= '0;
               trunc_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
